mc8051_intc: RTL and testbench

Interrupt controller for the mc8051 core: the request side of the core's `int_req_n` / `int_ack_n` / `int_so_num` / `int_reti` interface. It latches up to N_SRC peripheral interrupt lines (edge or level mode per source). It arbitrates across two priority levels with 8051-style nesting, presents one committed request to the core, and tracks in-service state until the matching RETI. It sits beside `mc8051_top` in the SoC and drives its interrupt input pins directly.

---
 rtl/mc8051_intc_if.sv | 13 +
 rtl/mc8051_intc.sv | 98 +++++++++
 tb/tb_mc8051_intc.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mc8051_intc_if.sv
// mc8051_intc_if: interrupt handshake between mc8051_intc and the mc8051 core.
//   int_req_n  - request to core, active-low (driven by the controller)
//   int_so_num - index of the requested source, zero-extended (driven by the controller)
//   int_ack_n  - core acknowledge, active-low (driven by the core)
//   int_reti   - one-cycle pulse on RETI (driven by the core)
interface mc8051_intc_if;
    logic       int_req_n;
    logic [7:0] int_so_num;
    logic       int_ack_n;
    logic       int_reti;
    modport master (output int_req_n, output int_so_num, input int_ack_n, input int_reti);
    modport slave  (input int_req_n, input int_so_num, output int_ack_n, output int_reti);
endinterface

// File: rtl/mc8051_intc.sv
// mc8051_intc: two-level, 8051-style nesting interrupt controller for the mc8051 core.
//   clk, reset_n          - clock, asynchronous active-low reset
//   irq                   - peripheral requests, active-high
//   irq_en                - per-source enable
//   irq_edge              - 1 = rising-edge triggered, 0 = level triggered
//   irq_pri               - 1 = high priority, 0 = low priority
//   global_en             - master enable (EA)
//   bus                   - core handshake (int_req_n, int_so_num, int_ack_n, int_reti)
//   pending               - registered pending flags
//   in_service            - bit1 = high level in service, bit0 = low level in service
module mc8051_intc #(
    parameter int N_SRC = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_SRC-1:0]   irq,
    input  logic [N_SRC-1:0]   irq_en,
    input  logic [N_SRC-1:0]   irq_edge,
    input  logic [N_SRC-1:0]   irq_pri,
    input  logic               global_en,
    mc8051_intc_if.master      bus,
    output logic [N_SRC-1:0]   pending,
    output logic [1:0]         in_service
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t           state;
    logic             req_pri;
    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] pending_next;
    logic [N_SRC-1:0] base;
    logic [N_SRC-1:0] elig_hi;
    logic [N_SRC-1:0] elig_lo;
    logic [N_SRC-1:0] sel;
    logic             any_hi;
    logic             ack;
    logic [7:0]       win;
    logic [1:0]       is_reti;
    logic [1:0]       is_next;

    assign ack  = (state == REQ) && !bus.int_ack_n;
    assign rise = irq & ~irq_q;
    assign clr  = ack ? (N_SRC'(1) << bus.int_so_num) : '0;
    // A new edge in the acknowledge cycle outranks the acknowledge clear.
    assign pending_next = (irq_edge & (rise | (pending & ~clr))) | (~irq_edge & irq);

    // High level is masked only by high in service; low is masked by either level.
    assign base    = pending & irq_en & {N_SRC{global_en}};
    assign elig_hi = base & irq_pri & {N_SRC{~in_service[1]}};
    assign elig_lo = base & ~irq_pri & {N_SRC{in_service == 2'b00}};
    assign any_hi  = |elig_hi;
    assign sel     = any_hi ? elig_hi : elig_lo;

    always_comb begin
        win = 8'd0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (sel[i]) win = 8'(i);
    end

    // RETI retires the highest active level before the acknowledge adds the new one.
    assign is_reti = bus.int_reti ? (in_service[1] ? {1'b0, in_service[0]} : 2'b00) : in_service;
    assign is_next = ack ? (is_reti | (req_pri ? 2'b10 : 2'b01)) : is_reti;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            req_pri        <= 1'b0;
            irq_q          <= '0;
            pending        <= '0;
            in_service     <= 2'b00;
            bus.int_req_n  <= 1'b1;
            bus.int_so_num <= 8'd0;
        end else begin
            irq_q      <= irq;
            pending    <= pending_next;
            in_service <= is_next;
            case (state)
                IDLE:
                    if (|sel) begin
                        bus.int_so_num <= win;
                        req_pri        <= any_hi;
                        bus.int_req_n  <= 1'b0;
                        state          <= REQ;
                    end
                REQ:
                    if (!bus.int_ack_n) begin
                        bus.int_req_n <= 1'b1;
                        state         <= HOLD;
                    end
                HOLD:
                    if (bus.int_ack_n) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mc8051_intc.sv
// tb_mc8051_intc: table-driven self-checking bench for mc8051_intc.
module tb_mc8051_intc;
    typedef struct {
        logic [7:0] irq;
        logic [7:0] en;
        logic       ack_n;
        logic       reti;
        logic       req_n;
        logic [7:0] so;
        logic [7:0] pend;
        logic [1:0] is;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] irq = 8'h00;
    logic [7:0] irq_en = 8'hFF;
    logic [7:0] irq_edge = 8'hFE;
    logic [7:0] irq_pri = 8'h60;
    logic       global_en = 1'b1;
    logic [7:0] pending;
    logic [1:0] in_service;
    int         n_chk = 0;
    int         n_fail = 0;
    vec_t       v[$];

    mc8051_intc_if bus();

    mc8051_intc #(.N_SRC(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .irq(irq),
        .irq_en(irq_en),
        .irq_edge(irq_edge),
        .irq_pri(irq_pri),
        .global_en(global_en),
        .bus(bus),
        .pending(pending),
        .in_service(in_service)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [7:0] i, logic [7:0] e, logic a, logic r,
                                logic q, logic [7:0] s, logic [7:0] p, logic [1:0] is);
        vec_t t;
        t.irq = i; t.en = e; t.ack_n = a; t.reti = r;
        t.req_n = q; t.so = s; t.pend = p; t.is = is;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input int idx, input logic q, input logic [7:0] s, input logic [7:0] p, input logic [1:0] is);
        chk("int_req_n", idx, 32'(bus.int_req_n), 32'(q));
        chk("int_so_num", idx, 32'(bus.int_so_num), 32'(s));
        chk("pending", idx, 32'(pending), 32'(p));
        chk("in_service", idx, 32'(in_service), 32'(is));
    endtask

    initial begin
        // source 3 edge, low
        v.push_back(mk(8'h08, 8'hFF, 1, 0, 1, 8'h00, 8'h08, 2'b00));
        v.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 8'h03, 8'h08, 2'b00));
        v.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 8'h03, 8'h08, 2'b00));
        v.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h03, 8'h00, 2'b01));
        v.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h03, 8'h00, 2'b01));
        v.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 8'h03, 8'h00, 2'b01));
        v.push_back(mk(8'h00, 8'hFF, 1, 1, 1, 8'h03, 8'h00, 2'b00));
        v.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 8'h03, 8'h00, 2'b00));
        // sources 2 (low) and 5 (high) together
        v.push_back(mk(8'h24, 8'hFF, 1, 0, 1, 8'h03, 8'h24, 2'b00));
        v.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 8'h05, 8'h24, 2'b00));
        v.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h05, 8'h04, 2'b10));
        v.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 8'h05, 8'h04, 2'b10));
        v.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 8'h05, 8'h04, 2'b10));
        v.push_back(mk(8'h00, 8'hFF, 1, 1, 1, 8'h05, 8'h04, 2'b00));
        v.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 8'h02, 8'h04, 2'b00));
        v.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h02, 8'h00, 2'b01));
        v.push_back(mk(8'h00, 8'hFF, 1, 1, 1, 8'h02, 8'h00, 2'b00));
        // nesting: 1 low in service, 6 high arrives
        v.push_back(mk(8'h02, 8'hFF, 1, 0, 1, 8'h02, 8'h02, 2'b00));
        v.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 8'h01, 8'h02, 2'b00));
        v.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h01, 8'h00, 2'b01));
        v.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 8'h01, 8'h00, 2'b01));
        v.push_back(mk(8'h40, 8'hFF, 1, 0, 1, 8'h01, 8'h40, 2'b01));
        v.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 8'h06, 8'h40, 2'b01));
        v.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h06, 8'h00, 2'b11));
        v.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 8'h06, 8'h00, 2'b11));
        v.push_back(mk(8'h00, 8'hFF, 1, 1, 1, 8'h06, 8'h00, 2'b01));
        v.push_back(mk(8'h00, 8'hFF, 1, 1, 1, 8'h06, 8'h00, 2'b00));
        v.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 8'h06, 8'h00, 2'b00));
        // level source 0 held high
        v.push_back(mk(8'h01, 8'hFF, 1, 0, 1, 8'h06, 8'h01, 2'b00));
        v.push_back(mk(8'h01, 8'hFF, 1, 0, 0, 8'h00, 8'h01, 2'b00));
        v.push_back(mk(8'h01, 8'hFF, 0, 0, 1, 8'h00, 8'h01, 2'b01));
        v.push_back(mk(8'h01, 8'hFF, 1, 0, 1, 8'h00, 8'h01, 2'b01));
        v.push_back(mk(8'h01, 8'hFF, 1, 0, 1, 8'h00, 8'h01, 2'b01));
        v.push_back(mk(8'h01, 8'hFF, 1, 1, 1, 8'h00, 8'h01, 2'b00));
        v.push_back(mk(8'h01, 8'hFF, 1, 0, 0, 8'h00, 8'h01, 2'b00));
        v.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 8'h00, 8'h00, 2'b01));
        v.push_back(mk(8'h00, 8'hFF, 1, 1, 1, 8'h00, 8'h00, 2'b00));
        // level source 0 with irq_en[0]=0
        v.push_back(mk(8'h01, 8'hFE, 1, 0, 1, 8'h00, 8'h01, 2'b00));
        v.push_back(mk(8'h01, 8'hFE, 1, 0, 1, 8'h00, 8'h01, 2'b00));
        v.push_back(mk(8'h00, 8'hFE, 1, 0, 1, 8'h00, 8'h00, 2'b00));
        // source 4 re-edges in the acknowledge cycle
        v.push_back(mk(8'h10, 8'hFF, 1, 0, 1, 8'h00, 8'h10, 2'b00));
        v.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 8'h04, 8'h10, 2'b00));
        v.push_back(mk(8'h10, 8'hFF, 0, 0, 1, 8'h04, 8'h10, 2'b01));
        v.push_back(mk(8'h10, 8'hFF, 1, 0, 1, 8'h04, 8'h10, 2'b01));
        v.push_back(mk(8'h00, 8'hFF, 1, 1, 1, 8'h04, 8'h10, 2'b00));
        v.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 8'h04, 8'h10, 2'b00));

        bus.int_ack_n = 1'b1;
        bus.int_reti  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all(100 + i, 1'b1, 8'h00, 8'h00, 2'b00);
        end

        foreach (v[i]) begin
            irq = v[i].irq;
            irq_en = v[i].en;
            bus.int_ack_n = v[i].ack_n;
            bus.int_reti = v[i].reti;
            tick();
            chk_all(i, v[i].req_n, v[i].so, v[i].pend, v[i].is);
        end

        // reset while the request for source 4 is committed
        bus.int_ack_n = 1'b1;
        bus.int_reti = 1'b0;
        irq = 8'h08;
        reset_n = 1'b0;
        #1;
        chk_all(200, 1'b1, 8'h00, 8'h00, 2'b00);
        tick();
        reset_n = 1'b1;
        // irq[3] held high through release counts as one edge
        tick();
        chk_all(201, 1'b1, 8'h00, 8'h08, 2'b00);
        irq = 8'h00;
        tick();
        chk_all(202, 1'b0, 8'h03, 8'h08, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
